// File: rtl/ripple_count_sampler_if.sv
// Valid/ready output channel of the ripple counter sampler.
// Carries {wrap_cnt, stable} words to the downstream consumer.
interface ripple_count_sampler_if #(
    parameter int WIDTH = 4,
    parameter int EXT   = 4
);
    logic                 out_valid;
    logic                 out_ready;
    logic [EXT+WIDTH-1:0] out_data;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/ripple_count_sampler.sv
// Samples an asynchronous ripple counter into the clk domain, filters
// ripple glitches, extends the count with a wrap counter and streams it.
module ripple_count_sampler #(
    parameter int WIDTH = 4,
    parameter int EXT   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       cnt_in,
    input  logic                   clr_ovf,
    output logic                   ovf,
    ripple_count_sampler_if.master out_if
);
    localparam int DW = EXT + WIDTH;

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;
    logic [WIDTH-1:0] s3_q;
    logic [WIDTH-1:0] stable_q;
    logic [WIDTH-1:0] stable_d;
    logic [EXT-1:0]   wrap_q;
    logic [EXT-1:0]   wrap_d;
    logic [EXT-1:0]   wrap_next;
    logic [DW-1:0]    data_q;
    logic [DW-1:0]    data_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             evt;
    logic             wrapped;
    logic             load;
    logic             drop;

    // A code must be seen on two consecutive cycles before it counts.
    always_comb begin
        evt       = (s2_q == s3_q) && (s2_q != stable_q);
        wrapped   = s2_q < stable_q;
        wrap_next = wrap_q + EXT'(wrapped);
        stable_d  = evt ? s2_q : stable_q;
        wrap_d    = evt ? wrap_next : wrap_q;
        load      = evt && ((state_q == IDLE) || out_if.out_ready);
        drop      = evt && (state_q == HOLD) && !out_if.out_ready;
        data_d    = load ? {wrap_next, s2_q} : data_q;
        ovf_d     = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (evt) state_d = HOLD;
            HOLD: if (!evt && out_if.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_if.out_valid = (state_q == HOLD);
        out_if.out_data  = data_q;
        ovf              = ovf_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q     <= '0;
            s2_q     <= '0;
            s3_q     <= '0;
            stable_q <= '0;
            wrap_q   <= '0;
            data_q   <= '0;
            ovf_q    <= 1'b0;
            state_q  <= IDLE;
        end else begin
            s1_q     <= cnt_in;
            s2_q     <= s1_q;
            s3_q     <= s2_q;
            stable_q <= stable_d;
            wrap_q   <= wrap_d;
            data_q   <= data_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
        end
    end
endmodule

// File: tb/tb_ripple_count_sampler.sv
// Directed bench for ripple_count_sampler: table of count steps with
// expected words, plus glitch, backpressure and reset sequences.
module tb_ripple_count_sampler;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] cnt_in = 4'd0;
    logic       clr_ovf = 1'b0;
    logic       ovf;

    int applied = 0;
    int errors  = 0;

    ripple_count_sampler_if #(.WIDTH(4), .EXT(4)) bus ();

    ripple_count_sampler #(.WIDTH(4), .EXT(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .cnt_in (cnt_in),
        .clr_ovf(clr_ovf),
        .ovf    (ovf),
        .out_if (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] cnt;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Word must appear exactly on the 4th negedge (3 edges after sampling).
    task automatic step_vec(input vec_t v);
        cnt_in = v.cnt;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 4) begin
                chk("valid_pulse", 32'(bus.out_valid), 32'd1);
                chk("data", 32'(bus.out_data), 32'(v.exp));
            end else begin
                chk("valid_quiet", 32'(bus.out_valid), 32'd0);
            end
        end
    endtask

    task automatic do_reset();
        reset  = 1'b0;
        cnt_in = 4'd0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        bus.out_ready = 1'b1;
    endtask

    initial begin
        int   n;
        logic [7:0] last;
        vec_t v;

        bus.out_ready = 1'b1;
        vecs.push_back('{4'd1, 8'h01});
        vecs.push_back('{4'd2, 8'h02});
        vecs.push_back('{4'd14, 8'h0E});
        vecs.push_back('{4'd15, 8'h0F});
        vecs.push_back('{4'd0, 8'h10});
        vecs.push_back('{4'd1, 8'h11});
        for (int k = 2; k <= 15; k++) begin
            vecs.push_back('{4'd8, 8'((k - 1) * 16 + 8)});
            vecs.push_back('{4'd0, 8'(k * 16)});
        end
        vecs.push_back('{4'd8, 8'hF8});
        vecs.push_back('{4'd0, 8'h00});
        vecs.push_back('{4'd7, 8'h07});

        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_data", 32'(bus.out_data), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        reset = 1'b1;

        foreach (vecs[i]) step_vec(vecs[i]);

        // 7 -> 8 presented with 1-cycle ripple codes 6, 4, 0.
        n    = 0;
        last = 8'h00;
        cnt_in = 4'd6;
        @(negedge clk);
        cnt_in = 4'd4;
        @(negedge clk);
        cnt_in = 4'd0;
        @(negedge clk);
        cnt_in = 4'd8;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                n++;
                last = bus.out_data;
            end
        end
        chk("glitch_events", 32'(n), 32'd1);
        chk("glitch_data", 32'(last), 32'h08);

        // Backpressure.
        do_reset();
        v = '{4'd3, 8'h03};
        step_vec(v);
        bus.out_ready = 1'b0;
        cnt_in = 4'd4;
        repeat (4) @(negedge clk);
        chk("bp_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_data4", 32'(bus.out_data), 32'h04);
        chk("bp_ovf0", 32'(ovf), 32'd0);
        cnt_in = 4'd5;
        repeat (4) @(negedge clk);
        chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_hold_data", 32'(bus.out_data), 32'h04);
        chk("bp_ovf1", 32'(ovf), 32'd1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("bp_drop", 32'(bus.out_valid), 32'd0);
        chk("bp_ovf_sticky", 32'(ovf), 32'd1);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        chk("bp_clr", 32'(ovf), 32'd0);

        // Event in HOLD coincides with out_ready.
        do_reset();
        step_vec(v);
        bus.out_ready = 1'b0;
        cnt_in = 4'd4;
        repeat (4) @(negedge clk);
        chk("sim_pre", 32'(bus.out_data), 32'h04);
        cnt_in = 4'd5;
        repeat (3) @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("sim_valid", 32'(bus.out_valid), 32'd1);
        chk("sim_data", 32'(bus.out_data), 32'h05);
        chk("sim_ovf", 32'(ovf), 32'd0);

        // Reset while holding with ovf set.
        cnt_in = 4'd6;
        repeat (4) @(negedge clk);
        chk("mid_ovf_set", 32'(ovf), 32'd1);
        chk("mid_hold", 32'(bus.out_data), 32'h05);
        #2;
        reset  = 1'b0;
        cnt_in = 4'd0;
        #1;
        chk("mid_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_data", 32'(bus.out_data), 32'd0);
        chk("mid_ovf", 32'(ovf), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        bus.out_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.out_valid) n++;
        end
        chk("post_rst_quiet", 32'(n), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
        $finish;
    end
endmodule

// File: doc/ripple_count_sampler.md
# ripple_count_sampler

Downstream consumer of the 4-bit asynchronous ripple counter. It brings the counter's `q` bus, which is asynchronous and glitchy during ripple transitions, into the system `clk` domain. It filters out intermediate ripple codes and extends the count with a wrap counter. Each new stable value is presented on a valid/ready output port, with a sticky overrun flag for values dropped under backpressure.

## Interface
- `WIDTH`, default 4: width of the ripple counter bus.
- `EXT`, default 4: width of the wrap (extension) counter.
- `clk` input 1: system clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-low reset. Held low means all state is cleared immediately.
- `cnt_in` input `WIDTH`: ripple counter `q` bus; asynchronous to `clk`; counts up and wraps from 2^WIDTH-1 to 0.
- `out_ready` input 1: downstream accepts `out_data` on a cycle where `out_valid && out_ready`.
- `clr_ovf` input 1: synchronous clear of `ovf`.
- `out_valid` output 1: `out_data` holds an unconsumed sample.
- `out_data` output `EXT+WIDTH`: `{wrap_cnt, stable}`.
- `ovf` output 1: sticky; a stable change was dropped while the output was held.

## Operation
- **Synchronizer**
  - `s1 <= cnt_in`, `s2 <= s1`: a 2-flop synchronizer per bit.
  - `s3 <= s2` holds the previous synchronized sample.
- **Stability filter**
  - A candidate is `s2`, qualified only when `s2 == s3`, i.e. identical on two consecutive cycles.
  - A change event occurs when the candidate is qualified and `s2 != stable`.
  - Intermediate ripple codes lasting under 2 cycles are never qualified.
- **Change event**
  - `stable <= s2`.
  - If `s2 < stable` (unsigned), a wrap has occurred: `wrap_cnt <= wrap_cnt + 1`, modulo 2^EXT, silently rolling over.
  - Skipped intermediate values on a fast counter are legal and are not errors. Only a numeric decrease counts as a wrap.
- **Output FSM, 2 states**
  - `IDLE` (`out_valid`=0): on a change event, load `out_data` = `{wrap_cnt_next, s2}`, set `out_valid`, go to `HOLD`.
  - `HOLD` (`out_valid`=1): `out_data` must not change. On `out_ready`, drop `out_valid` and go to `IDLE`.
  - Change event in `HOLD` without `out_ready`: `stable` and `wrap_cnt` still update, `out_data` is unchanged, and `ovf <= 1`.
  - Change event in `HOLD` with `out_ready` on the same cycle: the current word is consumed, the new word is loaded, `out_valid` stays 1, the FSM stays in `HOLD`, and `ovf` is unaffected.
- **`ovf`**
  - Set as above; cleared by `clr_ovf`.
  - Set has priority over clear on the same cycle.
- **Reset values**
  - `s1`, `s2`, `s3`, `stable`, `wrap_cnt`, `out_data` = 0.
  - `out_valid` = 0, `ovf` = 0, FSM = `IDLE`.
  - The counter also resets to 0, so no spurious event follows reset.
- **Reset mid-operation:** a pending word is discarded and there is no output activity until a new change event.

## Timing
- A `cnt_in` value first sampled by edge N gives `s2` at N+1 and `s3` at N+2. The event is qualified in cycle N+2, and `out_valid` and `out_data` are registered at edge N+3. Latency is 3 edges after the first sampling edge.
- Throughput is at most one change event per 2 cycles per distinct value. Stable changes faster than that may be skipped, and that is legal.
- All outputs are registered with no combinational path from inputs.
- `out_valid` is held until handshake; `out_data` is stable throughout `HOLD`.
- Asynchronous reset assertion takes effect without a clock edge. Deassertion is assumed to be synchronized externally to `clk`.

## Test plan
- **Reset then count:** reset low for 3 cycles. Then step `cnt_in` 0→1→2, each held 5 cycles, with `out_ready`=1. Expect `out_data` = 0x01 then 0x02, each `out_valid` a 1-cycle pulse, 3 edges after the change.
- **Wrap:** step `cnt_in` 14→15→0→1. Expect `out_data` 0x0E, 0x0F, 0x10, 0x11. Continue until `wrap_cnt` = 15, then wrap once more: expect `wrap_cnt` rolls to 0 and `out_data` = 0x00.
- **Ripple glitch:** transition 7→8 presented as 7→6→4→0→8 with each intermediate 1 cycle. Expect exactly one event, `out_data` = 0x08, and no wrap increment.
- **Backpressure:** `out_ready`=0; step 3→4→5. Expect `out_data` = 0x04 held, `ovf` = 1. Then `out_ready`=1 for 1 cycle: expect `out_valid` drops. Assert `clr_ovf`: expect `ovf` = 0.
- **Simultaneous:** in `HOLD` with `out_data`=0x04, a change event to 5 coincides with `out_ready`=1. Expect `out_valid` stays 1, `out_data` = 0x05, `ovf` unchanged.
- **Mid-operation reset:** assert reset while in `HOLD`. Expect immediate `out_valid` = 0, `out_data` = 0, `ovf` = 0, and no event after release while `cnt_in` = 0.
